// File: rtl/arq_frame_sender.sv
// Packs a byte stream into F6 28 + payload + CRC-8 frames, sends them 8N1 and optionally waits for ACK.
// Build macro SENDER_CORRUPT_EN adds i_corrupt_en, which flips bit 0 of payload[0] on a frame's first send.
module arq_frame_sender #(
  parameter int unsigned CLK_DIV     = 868,
  parameter int unsigned PYLD_LEN    = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pyld_data,
  input  logic       i_pyld_data_valid,
  output logic       o_pyld_data_req,
  input  logic       i_arq_en,
`ifdef SENDER_CORRUPT_EN
  input  logic       i_corrupt_en,
`endif
  output logic [7:0] o_crc_val,
  output logic       o_otn_rx_data,
  input  logic       i_otn_tx_ack,
  output logic       o_send_complete,
  output logic       o_retrans_req,
  output logic       o_fail
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned BYTE_W = $clog2(PYLD_LEN + 3);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IDX_W  = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
  localparam int unsigned BUF_D  = 2 ** IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]        state_q, state_n;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_n;
  logic [3:0]        bit_idx_q, bit_idx_n;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_n;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_n;
  logic [3:0]        retry_q, retry_n;
  logic              arq_q, arq_n;
  logic [7:0]        crc_acc_q, crc_acc_n;
  logic [7:0]        crc_val_n;
  logic              line_n, done_n, retrans_n, fail_n;
  logic              ack_s1_q, ack_s2_q, ack_d_q;
  logic              ack_edge_c, wr_en_c;
  logic [7:0]        tx_byte_c;
  logic [7:0]        buf_q [0:BUF_D-1];
`ifdef SENDER_CORRUPT_EN
  logic              corrupt_q, corrupt_n;
`endif

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign ack_edge_c = ack_s2_q & ~ack_d_q;

  // Byte currently on the wire: FAS, buffered payload, then the latched CRC
  always_comb begin
    tx_byte_c = o_crc_val;
    if (byte_idx_q == BYTE_W'(0))                 tx_byte_c = 8'hF6;
    else if (byte_idx_q == BYTE_W'(1))            tx_byte_c = 8'h28;
    else if (byte_idx_q < BYTE_W'(PYLD_LEN + 2))  tx_byte_c = buf_q[IDX_W'(byte_idx_q - BYTE_W'(2))];
`ifdef SENDER_CORRUPT_EN
    if (corrupt_q && byte_idx_q == BYTE_W'(2)) tx_byte_c[0] = ~tx_byte_c[0];
`endif
  end

  always_comb begin
    state_n    = state_q;
    byte_idx_n = byte_idx_q;
    bit_idx_n  = bit_idx_q;
    clk_cnt_n  = clk_cnt_q;
    to_cnt_n   = to_cnt_q;
    retry_n    = retry_q;
    arq_n      = arq_q;
    crc_acc_n  = crc_acc_q;
    crc_val_n  = o_crc_val;
    line_n     = o_otn_rx_data;
    done_n     = 1'b0;
    retrans_n  = 1'b0;
    fail_n     = 1'b0;
    wr_en_c    = 1'b0;
`ifdef SENDER_CORRUPT_EN
    corrupt_n  = corrupt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_pyld_data_valid) begin
          state_n    = S_LOAD;
          arq_n      = i_arq_en;
          retry_n    = '0;
          crc_acc_n  = '0;
          byte_idx_n = '0;
        end
      end
      S_LOAD: begin
        if (i_pyld_data_valid) begin
          wr_en_c   = 1'b1;
          crc_acc_n = crc8_byte(crc_acc_q, i_pyld_data);
          if (byte_idx_q == BYTE_W'(PYLD_LEN - 1)) begin
            crc_val_n  = crc8_byte(crc_acc_q, i_pyld_data);
            state_n    = S_SEND;
            byte_idx_n = '0;
            bit_idx_n  = '0;
            clk_cnt_n  = '0;
            line_n     = 1'b0;
`ifdef SENDER_CORRUPT_EN
            corrupt_n  = i_corrupt_en;
`endif
          end else begin
            byte_idx_n = byte_idx_q + BYTE_W'(1);
          end
        end
      end
      S_SEND: begin
        if (clk_cnt_q == CNT_W'(CLK_DIV - 1)) begin
          clk_cnt_n = '0;
          if (bit_idx_q == 4'd9) begin
            bit_idx_n = '0;
            if (byte_idx_q == BYTE_W'(PYLD_LEN + 2)) begin
              byte_idx_n = '0;
              line_n     = 1'b1;
`ifdef SENDER_CORRUPT_EN
              corrupt_n  = 1'b0;
`endif
              if (arq_q) begin
                state_n  = S_WAIT;
                to_cnt_n = '0;
              end else begin
                state_n = S_IDLE;
                done_n  = 1'b1;
              end
            end else begin
              byte_idx_n = byte_idx_q + BYTE_W'(1);
              line_n     = 1'b0;
            end
          end else begin
            bit_idx_n = bit_idx_q + 4'd1;
            line_n    = (bit_idx_q < 4'd8) ? tx_byte_c[bit_idx_q[2:0]] : 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // ACK wins over a timeout expiring in the same cycle
        if (ack_edge_c) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          to_cnt_n = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          to_cnt_n = '0;
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_n    = retry_q + 4'd1;
            retrans_n  = 1'b1;
            state_n    = S_SEND;
            byte_idx_n = '0;
            bit_idx_n  = '0;
            clk_cnt_n  = '0;
            line_n     = 1'b0;
          end else begin
            fail_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          to_cnt_n = to_cnt_q + TO_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      byte_idx_q      <= '0;
      bit_idx_q       <= '0;
      clk_cnt_q       <= '0;
      to_cnt_q        <= '0;
      retry_q         <= '0;
      arq_q           <= 1'b0;
      crc_acc_q       <= '0;
      o_crc_val       <= '0;
      o_otn_rx_data   <= 1'b1;
      o_pyld_data_req <= 1'b0;
      o_send_complete <= 1'b0;
      o_retrans_req   <= 1'b0;
      o_fail          <= 1'b0;
      ack_s1_q        <= 1'b0;
      ack_s2_q        <= 1'b0;
      ack_d_q         <= 1'b0;
`ifdef SENDER_CORRUPT_EN
      corrupt_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_n;
      byte_idx_q      <= byte_idx_n;
      bit_idx_q       <= bit_idx_n;
      clk_cnt_q       <= clk_cnt_n;
      to_cnt_q        <= to_cnt_n;
      retry_q         <= retry_n;
      arq_q           <= arq_n;
      crc_acc_q       <= crc_acc_n;
      o_crc_val       <= crc_val_n;
      o_otn_rx_data   <= line_n;
      o_pyld_data_req <= (state_n == S_LOAD);
      o_send_complete <= done_n;
      o_retrans_req   <= retrans_n;
      o_fail          <= fail_n;
      ack_s1_q        <= i_otn_tx_ack;
      ack_s2_q        <= ack_s1_q;
      ack_d_q         <= ack_s2_q;
`ifdef SENDER_CORRUPT_EN
      corrupt_q       <= corrupt_n;
`endif
    end
  end

  // Retransmit buffer; contents are only meaningful after a full load
  always_ff @(posedge i_clk) begin
    if (wr_en_c) buf_q[IDX_W'(byte_idx_q)] <= i_pyld_data;
  end

endmodule

// File: tb/tb_arq_frame_sender.sv
// Randomised bench for arq_frame_sender: decodes the 8N1 line and checks frames, CRC and ARQ timing.
module tb_arq_frame_sender;
  localparam int CD        = 4;
  localparam int PL        = 4;
  localparam int MR        = 2;
  localparam int TO        = 60;
  localparam int NB        = PL + 3;
  localparam int FRAME_CYC = 10 * NB * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pyld_data = 8'h00;
  logic       pyld_valid = 1'b0;
  logic       pyld_req;
  logic       arq_en = 1'b0;
  logic [7:0] crc_val;
  logic       line;
  logic       ack = 1'b0;
  logic       done, retrans, fail;
`ifdef SENDER_CORRUPT_EN
  logic       corrupt_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done = 0, n_retrans = 0, n_fail_pulse = 0;
  int last_done_cyc = -1, last_fail_cyc = -1;
  int retrans_cyc [0:7];
  logic [7:0] pl_q [0:PL-1];
  logic [7:0] rx_bytes [0:NB-1];
  bit rx_ok;
  int rx_start;
  int last_acc_cyc;

  arq_frame_sender #(
    .CLK_DIV(CD), .PYLD_LEN(PL), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pyld_data(pyld_data),
    .i_pyld_data_valid(pyld_valid),
    .o_pyld_data_req(pyld_req),
    .i_arq_en(arq_en),
`ifdef SENDER_CORRUPT_EN
    .i_corrupt_en(corrupt_en),
`endif
    .o_crc_val(crc_val),
    .o_otn_rx_data(line),
    .i_otn_tx_ack(ack),
    .o_send_complete(done),
    .o_retrans_req(retrans),
    .o_fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder
  always @(negedge clk) begin
    if (done === 1'b1) begin n_done <= n_done + 1; last_done_cyc <= cyc; end
    if (retrans === 1'b1) begin retrans_cyc[n_retrans & 7] <= cyc; n_retrans <= n_retrans + 1; end
    if (fail === 1'b1) begin n_fail_pulse <= n_fail_pulse + 1; last_fail_cyc <= cyc; end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // CRC-8/0x07 by serial bit-wise polynomial division, MSB first
  function automatic logic [7:0] model_crc();
    logic [7:0] r;
    bit fb;
    r = 8'h00;
    for (int b = 0; b < PL; b++)
      for (int k = 7; k >= 0; k--) begin
        fb = r[7] ^ pl_q[b][k];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input bit corrupt);
    logic [7:0] v;
    if (i == 0)           v = 8'hF6;
    else if (i == 1)      v = 8'h28;
    else if (i < PL + 2)  v = pl_q[i-2];
    else                  v = model_crc();
    if (corrupt && i == 2) v[0] = ~v[0];
    return v;
  endfunction

  function automatic int frame_first_bad(input bit corrupt);
    if (!rx_ok) return -2;
    for (int i = 0; i < NB; i++) if (rx_bytes[i] !== exp_byte(i, corrupt)) return i;
    return -1;
  endfunction

  function automatic string frame_msg(input int bad, input bit corrupt);
    if (bad == -2) return "got no clean 8N1 frame, required a full frame";
    return $sformatf("byte %0d got %02h required %02h", bad, rx_bytes[bad], exp_byte(bad, corrupt));
  endfunction

  task automatic rand_payload();
    for (int b = 0; b < PL; b++) pl_q[b] = 8'($urandom);
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 5000) begin @(posedge clk); #1; g++; end
  endtask

  // Drives pl_q through the valid/req handshake; leaves us #1 after the last accepting edge
  task automatic feed(input bit arq, input bit gaps);
    int i = 0;
    int guard = 0;
    bit acc;
    arq_en = arq;
    @(posedge clk); #1;
    pyld_valid = 1'b1;
    pyld_data  = pl_q[0];
    while (i < PL && guard < 200) begin
      @(negedge clk);
      acc = pyld_req && pyld_valid;
      @(posedge clk); #1;
      guard++;
      if (acc) begin i++; last_acc_cyc = cyc; end
      if (i < PL) begin
        pyld_data  = pl_q[i];
        pyld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else pyld_valid = 1'b0;
    end
    n_checks++;
    if (i != PL) begin n_fail++; $display("FAIL feed: accepted %0d bytes, required %0d", i, PL); end
  endtask

  // Called on a negedge; samples each bit mid-period
  task automatic capture_frame();
    int w = 0;
    rx_ok = 1'b1;
    while (line !== 1'b0 && w < 1000) begin @(negedge clk); w++; end
    if (line !== 1'b0) begin rx_ok = 1'b0; rx_start = -1; return; end
    rx_start = cyc;
    repeat (CD / 2) @(negedge clk);
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 10; k++) begin
        if (k == 0 && line !== 1'b0) rx_ok = 1'b0;
        else if (k == 9 && line !== 1'b1) rx_ok = 1'b0;
        else if (k > 0 && k < 9) rx_bytes[b][k-1] = line;
        if (!(b == NB - 1 && k == 9)) repeat (CD) @(negedge clk);
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (line !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b required 1", line); end
    n_checks++; if (pyld_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", pyld_req); end
    n_checks++; if (crc_val !== 8'h00) begin n_fail++; $display("FAIL reset_crc: got %02h required 00", crc_val); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (retrans !== 1'b0) begin n_fail++; $display("FAIL reset_retrans: got %b required 0", retrans); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b required 0", fail); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (line !== 1'b1 || pyld_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: line=%b req=%b required line=1 req=0", line, pyld_req);
    end
  endtask

  task automatic test_no_arq(input int nframes);
    int bad, d0, r0, f0;
    for (int f = 0; f < nframes; f++) begin
      if (f == 0 && nframes > 1)
        for (int b = 0; b < PL; b++) pl_q[b] = (b == PL - 1) ? 8'h01 : 8'h00;
      else rand_payload();
      d0 = n_done; r0 = n_retrans; f0 = n_fail_pulse;
      feed(1'b0, f == 2);
      @(negedge clk);
      n_checks++; if (pyld_req !== 1'b0) begin n_fail++; $display("FAIL noarq_req_drop: got %b required 0", pyld_req); end
      n_checks++; if (crc_val !== model_crc()) begin n_fail++; $display("FAIL noarq_crc: got %02h required %02h", crc_val, model_crc()); end
      if (f == 0 && nframes > 1) begin
        n_checks++; if (crc_val !== 8'h07) begin n_fail++; $display("FAIL crc_0001: got %02h required 07", crc_val); end
      end
      capture_frame();
      n_checks++; if (rx_start != last_acc_cyc) begin n_fail++; $display("FAIL noarq_start: got cycle %0d required %0d", rx_start, last_acc_cyc); end
      bad = frame_first_bad(1'b0);
      n_checks++; if (bad != -1) begin n_fail++; $display("FAIL noarq_frame: %s", frame_msg(bad, 1'b0)); end
      wait_cyc(rx_start + FRAME_CYC + 4);
      n_checks++; if (n_done - d0 != 1 || last_done_cyc != rx_start + FRAME_CYC) begin
        n_fail++; $display("FAIL noarq_done: got %0d pulses at %0d required 1 at %0d", n_done - d0, last_done_cyc, rx_start + FRAME_CYC);
      end
      n_checks++; if (n_retrans != r0 || n_fail_pulse != f0) begin
        n_fail++; $display("FAIL noarq_no_retry: got retrans=%0d fail=%0d required 0 0", n_retrans - r0, n_fail_pulse - f0);
      end
    end
  endtask

  task automatic test_arq_ack();
    int bad, d0, r0, dly, a;
    for (int it = 0; it < 2; it++) begin
      rand_payload();
      d0 = n_done; r0 = n_retrans;
      feed(1'b1, 1'b1);
      @(negedge clk);
      // An ACK toggling during SEND must not retire the frame
      fork
        capture_frame();
        begin repeat (60) @(posedge clk); #1 ack = 1'b1; repeat (8) @(posedge clk); #1 ack = 1'b0; end
      join
      bad = frame_first_bad(1'b0);
      n_checks++; if (bad != -1) begin n_fail++; $display("FAIL arq_frame: %s", frame_msg(bad, 1'b0)); end
      n_checks++; if (n_done != d0) begin n_fail++; $display("FAIL arq_send_ack_ignored: got %0d pulses required 0", n_done - d0); end
      dly = (it == 0) ? 50 : $urandom_range(1, 55);
      a = rx_start + FRAME_CYC + dly;
      wait_cyc(a);
      ack = 1'b1;
      wait_cyc(a + 6);
      ack = 1'b0;
      wait_cyc(a + 12);
      n_checks++; if (n_done - d0 != 1 || last_done_cyc != a + 3) begin
        n_fail++; $display("FAIL arq_ack_latency: got %0d pulses at %0d required 1 at %0d", n_done - d0, last_done_cyc, a + 3);
      end
      n_checks++; if (n_retrans != r0) begin n_fail++; $display("FAIL arq_no_retrans: got %0d required 0", n_retrans - r0); end
    end
  endtask

  task automatic test_retry_fail();
    int bad, d0, r0, f0;
    int s [0:2];
    rand_payload();
    d0 = n_done; r0 = n_retrans; f0 = n_fail_pulse;
    feed(1'b1, 1'b0);
    @(negedge clk);
    for (int t = 0; t <= MR; t++) begin
      capture_frame();
      s[t] = rx_start;
      bad = frame_first_bad(1'b0);
      n_checks++; if (bad != -1) begin n_fail++; $display("FAIL retry_frame%0d: %s", t, frame_msg(bad, 1'b0)); end
    end
    n_checks++; if (s[1] != s[0] + FRAME_CYC + TO || s[2] != s[1] + FRAME_CYC + TO) begin
      n_fail++; $display("FAIL retry_spacing: got starts %0d %0d %0d required step %0d", s[0], s[1], s[2], FRAME_CYC + TO);
    end
    wait_cyc(s[2] + FRAME_CYC + TO + 4);
    n_checks++; if (n_retrans - r0 != 2) begin n_fail++; $display("FAIL retry_count: got %0d required 2", n_retrans - r0); end
    n_checks++; if (retrans_cyc[r0 & 7] != s[1] || retrans_cyc[(r0 + 1) & 7] != s[2]) begin
      n_fail++; $display("FAIL retrans_align: got %0d %0d required %0d %0d", retrans_cyc[r0 & 7], retrans_cyc[(r0 + 1) & 7], s[1], s[2]);
    end
    n_checks++; if (n_fail_pulse - f0 != 1 || last_fail_cyc != s[2] + FRAME_CYC + TO) begin
      n_fail++; $display("FAIL fail_pulse: got %0d at %0d required 1 at %0d", n_fail_pulse - f0, last_fail_cyc, s[2] + FRAME_CYC + TO);
    end
    n_checks++; if (n_done != d0) begin n_fail++; $display("FAIL retry_no_done: got %0d required 0", n_done - d0); end
  endtask

  task automatic test_coincide();
    int bad, d0, r0, a;
    rand_payload();
    d0 = n_done; r0 = n_retrans;
    feed(1'b1, 1'b0);
    @(negedge clk);
    capture_frame();
    bad = frame_first_bad(1'b0);
    n_checks++; if (bad != -1) begin n_fail++; $display("FAIL coincide_frame: %s", frame_msg(bad, 1'b0)); end
    a = rx_start + FRAME_CYC + TO - 3;
    wait_cyc(a);
    ack = 1'b1;
    wait_cyc(a + 6);
    ack = 1'b0;
    wait_cyc(a + 30);
    n_checks++; if (n_done - d0 != 1 || last_done_cyc != a + 3) begin
      n_fail++; $display("FAIL coincide_done: got %0d at %0d required 1 at %0d", n_done - d0, last_done_cyc, a + 3);
    end
    n_checks++; if (n_retrans != r0 || line !== 1'b1) begin
      n_fail++; $display("FAIL coincide_no_retrans: got %0d retrans line=%b required 0 line=1", n_retrans - r0, line);
    end
  endtask

`ifdef SENDER_CORRUPT_EN
  task automatic test_corrupt();
    int bad, d0, a;
    rand_payload();
    d0 = n_done;
    corrupt_en = 1'b1;
    feed(1'b1, 1'b0);
    corrupt_en = 1'b0;
    @(negedge clk);
    n_checks++; if (crc_val !== model_crc()) begin n_fail++; $display("FAIL corrupt_crc: got %02h required %02h", crc_val, model_crc()); end
    capture_frame();
    bad = frame_first_bad(1'b1);
    n_checks++; if (bad != -1) begin n_fail++; $display("FAIL corrupt_first: %s", frame_msg(bad, 1'b1)); end
    capture_frame();
    bad = frame_first_bad(1'b0);
    n_checks++; if (bad != -1) begin n_fail++; $display("FAIL corrupt_retx_clean: %s", frame_msg(bad, 1'b0)); end
    a = rx_start + FRAME_CYC + 10;
    wait_cyc(a);
    ack = 1'b1;
    wait_cyc(a + 6);
    ack = 1'b0;
    wait_cyc(a + 10);
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL corrupt_done: got %0d required 1", n_done - d0); end
  endtask
`endif

  task automatic test_reset_mid();
    int bad, d0, w;
    rand_payload();
    feed(1'b0, 1'b0);
    @(negedge clk);
    repeat (30) @(negedge clk);
    w = 0;
    while (line !== 1'b0 && w < 40) begin @(negedge clk); w++; end
    n_checks++; if (line !== 1'b0) begin n_fail++; $display("FAIL midreset_setup: got line %b required 0", line); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (line !== 1'b1) begin n_fail++; $display("FAIL midreset_line_async: got %b required 1", line); end
    n_checks++; if (crc_val !== 8'h00 || pyld_req !== 1'b0 || done !== 1'b0 || retrans !== 1'b0 || fail !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got crc=%02h req=%b done=%b retx=%b fail=%b required all 0",
                         crc_val, pyld_req, done, retrans, fail);
    end
    @(negedge clk) rst = 1'b0;
    // Partially load a frame, then reset it away
    @(posedge clk); #1;
    pyld_valid = 1'b1;
    pyld_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    pyld_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    d0 = n_done;
    rand_payload();
    feed(1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (crc_val !== model_crc()) begin n_fail++; $display("FAIL midreset_crc: got %02h required %02h", crc_val, model_crc()); end
    capture_frame();
    bad = frame_first_bad(1'b0);
    n_checks++; if (bad != -1) begin n_fail++; $display("FAIL midreset_frame: %s", frame_msg(bad, 1'b0)); end
    wait_cyc(rx_start + FRAME_CYC + 4);
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL midreset_done: got %0d required 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_no_arq(3);
    test_arq_ack();
    test_retry_fail();
    test_no_arq(1);
    test_coincide();
`ifdef SENDER_CORRUPT_EN
    test_corrupt();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arq_frame_sender.md
# arq_frame_sender

Parametrised successor to the sender datapath. Accepts a byte stream on a valid/req handshake and packs it into fixed-length frames: 2-byte FAS, PYLD_LEN payload bytes, then a CRC-8 trailer. It holds each frame in an internal retransmit buffer and serialises it 8N1 onto the OTN line. With ARQ enabled it waits for an ACK, retransmits on timeout and gives up after MAX_RETRY attempts. It replaces the mapper/line-FIFO/tran_rec chain inside the sender top level.

## Interface
Parameters:
- CLK_DIV, 868: i_clk cycles per serial bit period (must be ≥ 4).
- PYLD_LEN, 16: payload bytes per frame (1..256).
- MAX_RETRY, 3: retransmissions allowed after the first send (0..15).
- TIMEOUT_CYC, 1000000: ACK wait, in cycles, measured from the end of the stop bit of the last byte.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pyld_data  in  8  payload byte.
- i_pyld_data_valid  in  1  payload byte available.
- o_pyld_data_req  out  1  block accepts a byte this cycle when valid is also high.
- i_arq_en  in  1  ARQ mode; sampled on the IDLE→LOAD transition.
- i_corrupt_en  in  1  corruption request; present only with SENDER_CORRUPT_EN.
- o_crc_val  out  8  CRC of the most recently loaded frame.
- o_otn_rx_data  out  1  serial line out; idle high.
- i_otn_tx_ack  in  1  asynchronous ACK from the far end.
- o_send_complete  out  1  one-cycle pulse when a frame is retired successfully.
- o_retrans_req  out  1  one-cycle pulse at the start of each retransmission.
- o_fail  out  1  one-cycle pulse when a frame is dropped after retries are exhausted.

## Operation
- Frame byte order: 0xF6, 0x28, payload[0..PYLD_LEN-1], CRC.
- CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR. Computed over the payload only, one byte per accepted cycle.
- Serial format: start bit (0), 8 data bits LSB first, stop bit (1), each bit CLK_DIV cycles. Bytes are sent back to back with no idle gap.
- State machine:
  - IDLE → LOAD when i_pyld_data_valid=1.
  - LOAD: o_pyld_data_req=1; each accepted byte is written to buffer[idx]. After byte PYLD_LEN-1, CRC is latched into o_crc_val and the block goes to SEND.
  - SEND: transmits 2+PYLD_LEN+1 bytes from FAS, buffer and CRC. Then goes to WAIT_ACK if ARQ is latched, else pulses o_send_complete and goes to IDLE.
  - WAIT_ACK: a rising edge of the synchronised ACK pulses o_send_complete and goes to IDLE. On timeout with retry_cnt < MAX_RETRY: retry_cnt++, pulse o_retrans_req, go to SEND. On timeout otherwise: pulse o_fail, go to IDLE.
- retry_cnt clears on IDLE→LOAD.
- i_otn_tx_ack passes through a 2-flop synchroniser plus an edge detector. Edges outside WAIT_ACK are ignored, including edges during SEND.
- o_pyld_data_req=0 in every state except LOAD.
- Counter widths: bit counter $clog2(CLK_DIV), byte index $clog2(PYLD_LEN+3), timeout counter $clog2(TIMEOUT_CYC+1). None may wrap; each counter resets at its terminal count.

## Timing
- Reset values: o_otn_rx_data=1, o_pyld_data_req=0, o_crc_val=0x00, o_send_complete=0, o_retrans_req=0, o_fail=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame forces the line high immediately (asynchronously). A partially loaded frame is discarded.
- LOAD: one byte per cycle at most; PYLD_LEN cycles minimum.
- The start bit begins on the cycle after the last payload byte is accepted.
- Frame duration: 10·(PYLD_LEN+3)·CLK_DIV cycles.
- The timeout counter starts on the cycle after the final stop bit ends.
- ACK→o_send_complete latency: 3 cycles (2-flop sync, edge detect, registered pulse).
- An ACK edge on the same cycle as timeout expiry takes priority: the frame completes and no retry is started.
- o_retrans_req is asserted in the same cycle the retransmitted start bit is driven.

## Configuration
- SENDER_CORRUPT_EN defined:
  - The i_corrupt_en port exists and is sampled on LOAD→SEND.
  - When it is high, the first transmission of the frame inverts bit 0 of payload[0] on the wire.
  - Buffer contents, CRC and all retransmissions are unaltered.
- SENDER_CORRUPT_EN undefined: the port and logic are absent and frames are always sent clean.

## Test plan
- PYLD_LEN=1, CLK_DIV=4, arq=0, send byte 0x01 → o_crc_val=0x07. Line shows F6, 28, 01, 07 over 160 cycles. o_send_complete pulses once. o_pyld_data_req drops after 1 byte.
- PYLD_LEN=4, arq=1, ACK pulse 50 cycles after the stop bit → o_send_complete 3 cycles after the edge. No o_retrans_req.
- arq=1, MAX_RETRY=2, no ACK → frame sent 3 times. o_retrans_req pulses twice, then o_fail pulses once. Block returns to IDLE and accepts the next byte.
- Macro defined, corrupt_en=1, PYLD_LEN=1, byte 0x00 → first transmission payload is 0x01 with CRC 0x00. After timeout the retransmission payload is 0x00.
- Reset asserted mid-payload bit → line high in the same cycle and all outputs at reset values. The next frame is loaded from index 0.
- ACK edge coinciding with timeout expiry → o_send_complete pulses, no o_retrans_req.
